// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: frames a received symbol-pair stream for a Viterbi decoder core.
// It forwards the frame's information symbols and then appends TAIL zero symbols. It
// keeps feeding zero flush symbols until the core has returned len+TAIL decoded bits.
// Only the first len decoded bits are passed on. The tail decodes are counted and
// dropped. If the core never finishes, the flush timeout aborts the frame.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   start_i, frame_len_i              frame start request and length (IDLE only)
//   busy_o, done_o, err_o             status; done/err are one-cycle pulses
//   s_valid_i, s_ready_o, s_data_i    received symbol-pair stream
//   core_valid_o, core_data_o         symbols to the decoder core
//   core_valid_i, core_data_i         decoded bits from the core (never stalled)
//   m_valid_o, m_data_o, m_last_o     decoded frame bits, last marks final bit
module viterbi_frame_ctrl #(
  parameter int unsigned TBL       = 15,
  parameter int unsigned LEN_W     = 10,
  parameter int unsigned TAIL      = 2,
  parameter int unsigned FLUSH_MAX = TBL + 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [LEN_W-1:0] frame_len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [1:0]       s_data_i,
  output logic             core_valid_o,
  output logic [1:0]       core_data_o,
  input  logic             core_valid_i,
  input  logic             core_data_i,
  output logic             m_valid_o,
  output logic             m_data_o,
  output logic             m_last_o
);

  localparam int unsigned CW = LEN_W + 2;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DATA  = 3'd1;
  localparam logic [2:0] TAIL_ST = 3'd2;
  localparam logic [2:0] FLUSH = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CW-1:0]    in_cnt_q, in_cnt_d;
  logic [CW-1:0]    out_cnt_q, out_cnt_d;
  logic [CW-1:0]    flush_cnt_q, flush_cnt_d;
  logic             core_valid_q, core_valid_d;
  logic [1:0]       core_data_q, core_data_d;
  logic             m_valid_q, m_valid_d;
  logic             m_data_q, m_data_d;
  logic             m_last_q, m_last_d;
  logic             err_q, err_d;

  logic [CW-1:0] len_ext, end_cnt, out_cnt_inc;
  logic          active, strobe, complete;

  assign len_ext     = CW'(len_q);
  assign end_cnt     = len_ext + CW'(TAIL);
  assign out_cnt_inc = out_cnt_q + CW'(1);
  assign active      = (state_q == DATA) || (state_q == TAIL_ST) || (state_q == FLUSH);
  // Strobes outside an active frame are residue of earlier flush symbols; drop them.
  assign strobe      = active && core_valid_i;
  assign complete    = strobe && (out_cnt_inc == end_cnt);

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    core_valid_d = 1'b0;
    core_data_d  = 2'b00;
    m_valid_d    = 1'b0;
    m_data_d     = 1'b0;
    m_last_d     = 1'b0;
    err_d        = 1'b0;

    if (strobe) begin
      out_cnt_d = out_cnt_inc;
      if (out_cnt_q < len_ext) begin
        m_valid_d = 1'b1;
        m_data_d  = core_data_i;
        m_last_d  = (out_cnt_q == len_ext - CW'(1));
      end
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (frame_len_i != '0) begin
            len_d       = frame_len_i;
            in_cnt_d    = '0;
            out_cnt_d   = '0;
            flush_cnt_d = '0;
            state_d     = DATA;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (s_valid_i) begin
          core_valid_d = 1'b1;
          core_data_d  = s_data_i;
          in_cnt_d     = in_cnt_q + CW'(1);
          if (in_cnt_q == len_ext - CW'(1)) begin
            state_d = (TAIL == 0) ? FLUSH : TAIL_ST;
          end
        end
      end
      TAIL_ST: begin
        // in_cnt keeps counting through the tail: len..len+TAIL-1
        core_valid_d = 1'b1;
        in_cnt_d     = in_cnt_q + CW'(1);
        if (in_cnt_q == end_cnt - CW'(1)) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Completion wins over issuing another flush symbol.
        if (!complete) begin
          if (flush_cnt_q == CW'(FLUSH_MAX)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            core_valid_d = 1'b1;
            flush_cnt_d  = flush_cnt_q + CW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (complete) begin
      state_d = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      flush_cnt_q  <= '0;
      core_valid_q <= 1'b0;
      core_data_q  <= 2'b00;
      m_valid_q    <= 1'b0;
      m_data_q     <= 1'b0;
      m_last_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      core_valid_q <= core_valid_d;
      core_data_q  <= core_data_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      err_q        <= err_d;
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign err_o        = err_q;
  assign s_ready_o    = (state_q == DATA);
  assign core_valid_o = core_valid_q;
  assign core_data_o  = core_data_q;
  assign m_valid_o    = m_valid_q;
  assign m_data_o     = m_data_q;
  assign m_last_o     = m_last_q;

endmodule

// File: doc/viterbi_frame_ctrl.md
VITERBI_FRAME_CTRL -- requirements
Module: viterbi_frame_ctrl

Interface
REQ-001 Parameters (name, default, meaning): TBL, 15, decoder output latency in symbols; LEN_W, 10, frame-length width; TAIL, 2, zero tail symbols per frame (K-1); FLUSH_MAX, TBL+8, flush-symbol timeout limit.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start_i  in  1  frame start request, sampled only in IDLE.
REQ-005 frame_len_i  in  LEN_W  information symbols in frame; latched on accepted start.
REQ-006 busy_o  out  1  high in any state other than IDLE.
REQ-007 done_o  out  1  one-cycle pulse on frame completion.
REQ-008 err_o  out  1  one-cycle pulse: zero-length start or flush timeout.
REQ-009 s_valid_i / s_ready_o / s_data_i  in / out / in  1 / 1 / 2  received symbol-pair stream; transfer when valid and ready.
REQ-010 core_valid_o / core_data_o  out / out  1 / 2  symbol stream to the decoder core.
REQ-011 core_valid_i / core_data_i  in / in  1 / 1  decoded bit stream from the decoder core; cannot be stalled.
REQ-012 m_valid_o / m_data_o / m_last_o  out / out / out  1 / 1 / 1  decoded frame bits; no backpressure; last marks final frame bit.

Function
REQ-013 FSM states SHALL be IDLE, DATA, TAIL, FLUSH, DONE.
REQ-014 IDLE: start_i with frame_len_i != 0 SHALL latch length, clear in_cnt/out_cnt/flush_cnt, go to DATA next cycle.
REQ-015 IDLE: start_i with frame_len_i == 0 SHALL pulse err_o next cycle and stay in IDLE.
REQ-016 start_i outside IDLE SHALL be ignored.
REQ-017 s_ready_o SHALL be high only in DATA, combinationally from state.
REQ-018 Each DATA transfer SHALL produce core_valid_o=1, core_data_o=s_data_i on the next cycle (1-cycle registered latency); otherwise core_valid_o=0.
REQ-019 The transfer with in_cnt == len-1 SHALL move to TAIL; no further s_ready_o after it.
REQ-020 TAIL: exactly TAIL consecutive cycles of core_valid_o=1, core_data_o=2'b00, then FLUSH.
REQ-021 FLUSH: core_valid_o=1, core_data_o=2'b00 every cycle, flush_cnt incrementing, until out_cnt reaches len+TAIL.
REQ-022 out_cnt SHALL count core_valid_i strobes in DATA/TAIL/FLUSH only; strobes in IDLE/DONE SHALL be discarded.
REQ-023 Strobe with out_cnt < len SHALL yield, next cycle, m_valid_o=1, m_data_o=core_data_i; m_last_o=1 iff out_cnt == len-1.
REQ-024 Strobes with len <= out_cnt < len+TAIL (tail decodes) SHALL be counted but not forwarded.
REQ-025 When out_cnt reaches len+TAIL, the FSM SHALL enter DONE; DONE SHALL last one cycle with done_o=1, then IDLE.
REQ-026 out_cnt reaching len+TAIL SHALL take priority over issuing further flush symbols in that cycle.
REQ-027 flush_cnt reaching FLUSH_MAX without completion SHALL pulse err_o, suppress done_o, return to IDLE.
REQ-028 Counters SHALL be LEN_W+2 bits wide; no wrap within any legal frame (max len 2^LEN_W-1).
REQ-029 Symbol-stream gaps (s_valid_i low in DATA) SHALL stall input without affecting out_cnt.

Reset
REQ-030 rst high at a clock edge SHALL force IDLE and clear all counters and length register.
REQ-031 During/after reset: busy_o, done_o, err_o, s_ready_o, core_valid_o, core_data_o, m_valid_o, m_data_o, m_last_o SHALL be 0.
REQ-032 Reset mid-frame SHALL abort without done_o or err_o; the next start_i SHALL begin a clean frame.

Verification
REQ-033 len=4, 4 error-free symbols back-to-back, core model TBL=15 -> 4 core symbols, 2 tail 00, flush until 6 core strobes; m_valid_o 4 pulses, m_last_o on 4th; done_o one pulse; busy_o low next cycle.
REQ-034 len=0 start -> err_o pulse one cycle later, busy_o stays 0, no core_valid_o.
REQ-035 len=8, s_valid_i toggled every other cycle -> s_ready_o stays 1 in DATA, exactly 8 data core symbols then 2 tail, same output bits as gap-free run.
REQ-036 Core model never strobes core_valid_i -> exactly FLUSH_MAX flush symbols (23 at TBL=15), err_o pulse, no done_o, IDLE.
REQ-037 rst asserted after 3 of 10 symbols -> all outputs 0 next cycle; new start len=2 completes normally with 2 m_valid_o pulses.
REQ-038 start_i pulsed while busy plus residual core strobes in IDLE -> ignored; no m_valid_o outside a frame.
